// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
//  Module  : cpu_ctrl_pkg
//  Brief   : Opcode, state, ALU-op and PC-source encodings of the multi-cycle core.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_LBU  = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BGT  = 4'h8;
    localparam logic [3:0] OP_BLT  = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_ILL  = 4'hF;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC     = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_WB       = 4'd6;
    localparam logic [3:0] S_BRANCH   = 4'd7;
    localparam logic [3:0] S_HALT     = 4'd8;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    localparam logic [1:0] PC_SRC_INC    = 2'd0;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd1;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd2;
    localparam logic [1:0] PC_SRC_RET    = 2'd3;

    typedef enum logic [3:0] {
        CLS_ALU_R   = 4'd0,
        CLS_ALU_I   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JUMP    = 4'd5,
        CLS_CALL    = 4'd6,
        CLS_RET     = 4'd7,
        CLS_ILLEGAL = 4'd8
    } instr_class_e;

    // Flags come from the Rd - Rs1 subtraction performed in the branch state.
    function automatic logic branch_taken(input logic [3:0] op,
                                          input logic       z,
                                          input logic       n);
        case (op)
            OP_BGT:  return !z && !n;
            OP_BLT:  return n;
            OP_BEQ:  return z;
            OP_BNE:  return !z;
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
//  Module  : ctrl_decode
//  Brief   : Combinational opcode to instruction-class mapping.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_decode (
    input  logic [3:0]                 opcode_i,
    output cpu_ctrl_pkg::instr_class_e instr_class_o
);
    import cpu_ctrl_pkg::*;

    always_comb begin
        instr_class_o = CLS_ILLEGAL;
        case (opcode_i)
            OP_AND, OP_ADD, OP_SUB:          instr_class_o = CLS_ALU_R;
            OP_ADDI, OP_ANDI:                instr_class_o = CLS_ALU_I;
            OP_LW, OP_LBU:                   instr_class_o = CLS_LOAD;
            OP_SW:                           instr_class_o = CLS_STORE;
            OP_BGT, OP_BLT, OP_BEQ, OP_BNE:  instr_class_o = CLS_BRANCH;
            OP_JMP:                          instr_class_o = CLS_JUMP;
            OP_CALL:                         instr_class_o = CLS_CALL;
            OP_RET:                          instr_class_o = CLS_RET;
            default:                         instr_class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
//  Module  : multicycle_control
//  Brief   : Main sequencing FSM of the multi-cycle core; all strobes are
//            combinational from state, opcode, flags and mem_ready.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       negative,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       ra_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel,
    output logic       load_byte,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       wb_sel,
    output logic       retire,
    output logic       halted
);
    import cpu_ctrl_pkg::*;

    logic [3:0]   state_q;
    logic [3:0]   state_d;
    instr_class_e w_cls;

    ctrl_decode u_decode (
        .opcode_i      (opcode),
        .instr_class_o (w_cls)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Every strobe is forced low while reset is asserted, whatever the state.
    always_comb begin
        state_d   = state_q;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_INC;
        reg_write = 1'b0;
        ra_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr_sel  = 1'b0;
        load_byte = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = ALU_ADD;
        wb_sel    = 1'b0;
        retire    = 1'b0;
        halted    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_INC;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (w_cls)
                        CLS_ALU_R, CLS_ALU_I: state_d = S_EXEC;
                        CLS_LOAD, CLS_STORE:  state_d = S_MEM_ADDR;
                        CLS_BRANCH:           state_d = S_BRANCH;
                        CLS_JUMP, CLS_CALL: begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_JUMP;
                            ra_write = (w_cls == CLS_CALL);
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                        end
                        CLS_RET: begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_RET;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                        end
                        default:              state_d = S_HALT;
                    endcase
                end
                S_EXEC: begin
                    if (opcode == OP_AND || opcode == OP_ANDI) begin
                        alu_op = ALU_AND;
                    end else if (opcode == OP_SUB) begin
                        alu_op = ALU_SUB;
                    end else begin
                        alu_op = ALU_ADD;
                    end
                    alu_src_b = (w_cls == CLS_ALU_I);
                    state_d   = S_WB;
                end
                S_MEM_ADDR: begin
                    alu_op    = ALU_ADD;
                    alu_src_b = 1'b1;
                    state_d   = (w_cls == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_read  = 1'b1;
                    addr_sel  = 1'b1;
                    load_byte = (opcode == OP_LBU);
                    if (mem_ready) begin
                        state_d = S_WB;
                    end
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    addr_sel  = 1'b1;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = (w_cls == CLS_LOAD);
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_op = ALU_SUB;
                    if (branch_taken(opcode, zero, negative)) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_BRANCH;
                    end
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
//  Module  : tb_multicycle_control
//  Brief   : Directed self-checking bench; expected strobes come from a
//            per-instruction cycle script derived from the instruction's class.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       ra_write;
        logic       mem_read;
        logic       mem_write;
        logic       addr_sel;
        logic       load_byte;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       wb_sel;
        logic       retire;
        logic       halted;
    } outs_t;

    typedef struct packed {
        logic  rdy;
        logic  rst;
        outs_t exp;
    } step_t;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic       zero;
    logic       negative;
    logic       mem_ready;
    logic       ir_write, pc_write, reg_write, ra_write, mem_read, mem_write;
    logic       addr_sel, load_byte, alu_src_b, wb_sel, retire, halted;
    logic [1:0] pc_src, alu_op;

    multicycle_control dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .zero      (zero),
        .negative  (negative),
        .mem_ready (mem_ready),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .ra_write  (ra_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr_sel  (addr_sel),
        .load_byte (load_byte),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .wb_sel    (wb_sel),
        .retire    (retire),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    outs_t   act;
    outs_t   exp_o;
    logic    chk_en;
    int      checks;
    int      errors;
    string   tag;
    step_t   steps[$];
    logic [3:0] cur_op;
    logic    cur_z;
    logic    cur_n;

    assign act = {ir_write, pc_write, pc_src, reg_write, ra_write, mem_read,
                  mem_write, addr_sel, load_byte, alu_src_b, alu_op, wb_sel,
                  retire, halted};

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("FAIL %s outputs actual %b required %b (ir pcw pcsrc rw ra mr mw as lb sb aluop wb ret hlt) t=%0t",
                         tag, act, exp_o, $time);
            end
            checks++;
            if (mem_read && mem_write) begin
                errors++;
                $display("FAIL %s rd_wr_exclusive actual both=1 required at most one t=%0t", tag, $time);
            end
        end
    end

    task automatic add_step(input logic rdy, input logic rst, input outs_t e);
        step_t s;
        s.rdy = rdy;
        s.rst = rst;
        s.exp = e;
        steps.push_back(s);
    endtask

    // Expected per-cycle strobes for one instruction: fw/mw are the numbers of
    // mem_ready-low cycles in the fetch and data access, ir is mem_ready
    // driven in cycles where no memory request is pending.
    task automatic build(input logic [3:0] op, input logic z, input logic n,
                         input int fw, input int mw, input logic ir);
        outs_t o;
        int    k;
        logic  taken;
        k      = int'(op);
        cur_op = op;
        cur_z  = z;
        cur_n  = n;
        steps.delete();
        for (int i = 0; i < fw; i++) begin
            o = '0; o.mem_read = 1'b1;
            add_step(1'b0, 1'b0, o);
        end
        o = '0; o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
        add_step(1'b1, 1'b0, o);
        if (k <= 4) begin
            add_step(ir, 1'b0, '0);
            o = '0;
            o.alu_op    = (k == 0 || k == 4) ? 2'b10 : (k == 2) ? 2'b01 : 2'b00;
            o.alu_src_b = (k >= 3);
            add_step(ir, 1'b0, o);
            o = '0; o.reg_write = 1'b1; o.retire = 1'b1;
            add_step(ir, 1'b0, o);
        end else if (k <= 7) begin
            add_step(ir, 1'b0, '0);
            o = '0; o.alu_src_b = 1'b1;
            add_step(ir, 1'b0, o);
            if (k == 7) begin
                for (int i = 0; i < mw; i++) begin
                    o = '0; o.mem_write = 1'b1; o.addr_sel = 1'b1;
                    add_step(1'b0, 1'b0, o);
                end
                o = '0; o.mem_write = 1'b1; o.addr_sel = 1'b1; o.retire = 1'b1;
                add_step(1'b1, 1'b0, o);
            end else begin
                for (int i = 0; i <= mw; i++) begin
                    o = '0; o.mem_read = 1'b1; o.addr_sel = 1'b1;
                    o.load_byte = (k == 6);
                    add_step((i == mw), 1'b0, o);
                end
                o = '0; o.reg_write = 1'b1; o.wb_sel = 1'b1; o.retire = 1'b1;
                add_step(ir, 1'b0, o);
            end
        end else if (k <= 11) begin
            add_step(ir, 1'b0, '0);
            case (k)
                8:       taken = !z && !n;
                9:       taken = n;
                10:      taken = z;
                default: taken = !z;
            endcase
            o = '0; o.alu_op = 2'b01; o.retire = 1'b1;
            if (taken) begin
                o.pc_write = 1'b1; o.pc_src = 2'd2;
            end
            add_step(ir, 1'b0, o);
        end else if (k <= 14) begin
            o = '0; o.pc_write = 1'b1; o.retire = 1'b1;
            o.pc_src   = (k == 14) ? 2'd3 : 2'd1;
            o.ra_write = (k == 13);
            add_step(ir, 1'b0, o);
        end else begin
            add_step(ir, 1'b0, '0);
        end
    endtask

    task automatic truncate_with_reset(input int keep);
        while (steps.size() > keep) void'(steps.pop_back());
        add_step(1'b0, 1'b1, '0);
    endtask

    // exp_lat is the hand-computed cycle of the single retire; 0 means none.
    task automatic run(input string name, input int exp_lat);
        int nret;
        int first;
        nret  = 0;
        first = 0;
        foreach (steps[i]) begin
            @(posedge clk);
            #1;
            tag       = name;
            reset     = steps[i].rst;
            mem_ready = steps[i].rdy;
            opcode    = cur_op;
            zero      = cur_z;
            negative  = cur_n;
            exp_o     = steps[i].exp;
            chk_en    = 1'b1;
            @(negedge clk);
            if (retire) begin
                nret++;
                if (first == 0) first = i + 1;
            end
        end
        checks++;
        if (exp_lat == 0) begin
            if (nret != 0) begin
                errors++;
                $display("FAIL %s no_retire actual %0d retires required 0", name, nret);
            end
        end else if (nret != 1 || first != exp_lat) begin
            errors++;
            $display("FAIL %s latency actual %0d (retires %0d) required %0d (retires 1)",
                     name, first, nret, exp_lat);
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 4'h0;
        zero      = 1'b0;
        negative  = 1'b0;
        chk_en    = 1'b0;
        exp_o     = '0;
        checks    = 0;
        errors    = 0;
        tag       = "init";

        build(4'h1, 1'b0, 1'b0, 0, 0, 1'b1);
        truncate_with_reset(0);
        steps[0].rdy = 1'b1;
        add_step(1'b1, 1'b1, '0);
        add_step(1'b1, 1'b1, '0);
        run("reset", 0);

        build(4'h1, 1'b0, 1'b0, 0, 0, 1'b1); run("add", 4);
        build(4'h6, 1'b0, 1'b0, 0, 2, 1'b1); run("lbu_wait2", 7);
        build(4'h5, 1'b0, 1'b0, 1, 0, 1'b0); run("lw_fetchwait", 6);
        build(4'h7, 1'b0, 1'b0, 0, 1, 1'b1); run("sw_wait1", 5);
        build(4'h7, 1'b0, 1'b0, 0, 0, 1'b0); run("sw", 4);
        build(4'h0, 1'b1, 1'b1, 0, 0, 1'b0); run("and", 4);
        build(4'h2, 1'b0, 1'b1, 0, 0, 1'b1); run("sub", 4);
        build(4'h3, 1'b0, 1'b0, 0, 0, 1'b1); run("addi", 4);
        build(4'h4, 1'b0, 1'b0, 2, 0, 1'b0); run("andi_fetchwait", 6);

        build(4'h8, 1'b0, 1'b0, 0, 0, 1'b1); run("bgt_taken", 3);
        build(4'h8, 1'b1, 1'b0, 0, 0, 1'b1); run("bgt_zero", 3);
        build(4'h8, 1'b0, 1'b1, 0, 0, 1'b1); run("bgt_neg", 3);
        build(4'h9, 1'b0, 1'b1, 0, 0, 1'b1); run("blt_taken", 3);
        build(4'h9, 1'b0, 1'b0, 0, 0, 1'b0); run("blt_not", 3);
        build(4'hA, 1'b1, 1'b0, 0, 0, 1'b1); run("beq_taken", 3);
        build(4'hA, 1'b0, 1'b1, 0, 0, 1'b1); run("beq_not", 3);
        build(4'hB, 1'b1, 1'b0, 0, 0, 1'b1); run("bne_zero", 3);
        build(4'hB, 1'b0, 1'b0, 0, 0, 1'b1); run("bne_taken", 3);

        build(4'hC, 1'b0, 1'b0, 0, 0, 1'b1); run("jmp", 2);
        build(4'hD, 1'b0, 1'b0, 0, 0, 1'b1); run("call", 2);
        build(4'hE, 1'b0, 1'b0, 0, 0, 1'b0); run("ret", 2);

        // Reset while the store waits for memory: F, D, MA, one wait, then reset.
        build(4'h7, 1'b0, 1'b0, 0, 3, 1'b1);
        truncate_with_reset(4);
        run("sw_reset_wait", 0);
        build(4'h1, 1'b0, 1'b0, 0, 0, 1'b1); run("add_after_reset", 4);

        build(4'h5, 1'b0, 1'b0, 3, 0, 1'b1);
        truncate_with_reset(2);
        run("fetch_reset_wait", 0);
        build(4'hD, 1'b0, 1'b0, 0, 0, 1'b1); run("call_after_reset", 2);

        build(4'hF, 1'b0, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            outs_t h;
            h = '0; h.halted = 1'b1;
            add_step(logic'(i % 2), 1'b0, h);
        end
        add_step(1'b1, 1'b1, '0);
        run("halt", 0);
        build(4'h2, 1'b0, 1'b0, 0, 0, 1'b1); run("sub_after_halt", 4);

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Main sequencing FSM of the multi-cycle RISC core. Decodes the 4-bit opcode of the instruction register, steps the shared datapath through fetch/decode/execute/memory/write-back, and generates every register, ALU, memory and PC strobe. Resolves branch conditions from ALU flags in its own branch state and handshakes with a single shared instruction/data memory port via `mem_ready`.

## Interface
- Parameters: none; encodings are fixed constants in the package.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `opcode`  in  4  IR[15:12], stable from DECODE until the next FETCH completes
- `zero`  in  1  ALU result == 0, combinational, same cycle
- `negative`  in  1  ALU result < 0, combinational, same cycle
- `mem_ready`  in  1  memory completes the current `mem_read`/`mem_write` this cycle
- `ir_write`  out  1  load IR from memory data
- `pc_write`  out  1  load PC from `pc_src` mux
- `pc_src`  out  2  0=PC+1, 1=jump target, 2=branch target, 3=return register
- `reg_write`  out  1  register-file write
- `ra_write`  out  1  write PC (already PC+1) to return register
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `addr_sel`  out  1  0=PC, 1=ALU-out as memory address
- `load_byte`  out  1  zero-extend byte load
- `alu_src_b`  out  1  0=register, 1=immediate
- `alu_op`  out  2  00=ADD, 01=SUB, 10=AND
- `wb_sel`  out  1  0=ALU-out, 1=memory data
- `retire`  out  1  one-cycle pulse on instruction completion
- `halted`  out  1  illegal opcode seen; sticky until reset

## Operation
- Opcodes: 0000 AND, 0001 ADD, 0010 SUB, 0011 ADDI, 0100 ANDI, 0101 LW, 0110 LBU, 0111 SW, 1000 BGT, 1001 BLT, 1010 BEQ, 1011 BNE, 1100 JMP, 1101 CALL, 1110 RET, 1111 illegal.
- States: FETCH, DECODE, EXEC, MEM_ADDR, MEM_RD, MEM_WR, WB, BRANCH, HALT.
- FETCH: `mem_read`=1, `addr_sel`=0. Holds until `mem_ready`. On `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=0; go to DECODE.
- DECODE:
  - AND/ADD/SUB/ADDI/ANDI → EXEC
  - LW/LBU/SW → MEM_ADDR
  - branches → BRANCH
  - JMP: `pc_write`, `pc_src`=1, `retire` → FETCH
  - CALL: same as JMP plus `ra_write`
  - RET: `pc_write`, `pc_src`=3, `retire` → FETCH
  - 1111 → HALT
- EXEC: `alu_op` per opcode; `alu_src_b`=1 for ADDI/ANDI → WB.
- MEM_ADDR: ADD with `alu_src_b`=1 → MEM_RD (LW/LBU) or MEM_WR (SW).
- MEM_RD: `mem_read`=1, `addr_sel`=1, `load_byte`=1 for LBU; wait for `mem_ready` → WB.
- MEM_WR: `mem_write`=1, `addr_sel`=1; on `mem_ready`: `retire` → FETCH.
- WB: `reg_write`=1, `wb_sel`=1 after loads, else 0; `retire` → FETCH.
- BRANCH: `alu_op`=SUB (Rd−Rs1). Taken conditions:
  - BGT: `!zero && !negative`
  - BLT: `negative`
  - BEQ: `zero`
  - BNE: `!zero`
  - If taken: `pc_write`=1, `pc_src`=2.
  - Always: `retire` → FETCH.
- HALT: all strobes 0, `halted`=1; only `reset` exits.
- Any strobe not listed for a state is 0. `mem_read` and `mem_write` are never both 1.

## Timing
- State register updates on `clk`. Outputs are combinational from state, `opcode`, flags and `mem_ready`.
- While `reset`=1 and in the cycle after: state=FETCH, `halted`=0, every strobe gated to 0 during reset.
- Latency in cycles with `mem_ready` tied high:
  - ALU: 4
  - LW/LBU: 5
  - SW: 4
  - branch: 3
  - JMP/CALL/RET: 2
- Each low `mem_ready` cycle in FETCH/MEM_RD/MEM_WR adds one cycle. Request signals stay asserted and stable while waiting.
- `mem_ready` outside a request state is ignored.
- Reset mid-instruction or mid-wait: abandon immediately, no strobe in the reset cycle, restart at FETCH.
- Flags are sampled only in BRANCH.

## Structure
- Package `cpu_ctrl_pkg`: opcode constants, state enum, `alu_op` and `pc_src` encodings. Shared with the datapath.
- Natural sub-module: `ctrl_decode`, a combinational mapping opcode → instruction class (alu_r, alu_i, load, store, branch, jump, call, ret, illegal).

## Test plan
- Reset, then ADD (0001) with `mem_ready`=1 → states FETCH, DECODE, EXEC, WB. `reg_write`=1 only in WB; `retire` in cycle 4.
- LBU with `mem_ready` low 2 cycles in MEM_RD → `mem_read` and `addr_sel`=1 held 3 cycles; `load_byte`=1; WB has `wb_sel`=1; 7 cycles total.
- BGT with flags z=0,n=0 → `pc_write`=1, `pc_src`=2. BGT with z=1 → `pc_write`=0. BNE with z=1 → not taken.
- CALL → in DECODE: `ra_write`=1, `pc_write`=1, `pc_src`=1. RET → `pc_src`=3. Both in 2 cycles.
- Opcode 1111 → HALT, `halted`=1 for 20 cycles with all strobes 0. Reset clears to FETCH.
- Reset asserted in MEM_WR while waiting → `mem_write` drops in the reset cycle; no `retire`; FETCH follows.
